instruction_sequencer: RTL
==========================

# instruction_sequencer

Reads back the program held in instruction memory and issues it, one decoded instruction at a time, to the execution unit. It sits downstream of the switch-driven instruction entry path: that path writes 18-bit instructions into slots 0..DEPTH-1, and this block walks the slots in order from slot 0. For each slot it splits the word into opCode/regID1/regID2/immValue and holds it under a valid/ready handshake until the executor accepts it. The block stops on a HALT opcode or after the last programmed slot.

## Interface
- DEPTH, 10, number of instruction memory slots
- ADDR_W, 4, slot address width
- HALT_OP, 4'hF, opcode that terminates the program; never issued
- clock  in  1  sole clock, all logic on posedge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  begin program execution; sampled only in IDLE
- instrCount  in  ADDR_W  number of valid slots; values > DEPTH treated as DEPTH
- memAddr  out  ADDR_W  registered read address to instruction memory
- memData  in  18  instruction word; valid one cycle after memAddr is presented (synchronous read)
- opCode  out  4  memData[17:14] of current instruction
- regID1  out  3  memData[13:11]
- regID2  out  3  memData[10:8]
- immValue  out  8  memData[7:0]
- issueValid  out  1  decoded fields valid for executor
- issueReady  in  1  executor accepts current instruction
- pc  out  ADDR_W  slot index of current/next instruction
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when program ends

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, DONE.
- IDLE: on start=1:
  - limit = min(instrCount, DEPTH); limit latched internally.
  - limit==0: go to DONE; nothing fetched or issued.
  - else: pc<=0, memAddr<=0, go to FETCH.
- FETCH: memory samples memAddr; go to WAIT.
- WAIT: latch memData into opCode/regID1/regID2/immValue.
  - Latched opCode==HALT_OP: go to DONE; issueValid stays 0.
  - Otherwise: issueValid<=1, go to ISSUE.
- ISSUE: fields and issueValid held stable while issueReady=0. On issueValid&&issueReady:
  - issueValid<=0.
  - pc==limit-1: go to DONE.
  - Otherwise: pc<=pc+1, memAddr<=pc+1, go to FETCH.
- DONE: done=1 for exactly this cycle; go to IDLE. pc holds its final value.
- start outside IDLE is ignored; instrCount is sampled only with start.
- pc never exceeds DEPTH-1; there is no wrap-around to slot 0 within a run.
- Reset at any time (including mid-handshake): state IDLE next cycle, all outputs to reset values, in-flight instruction discarded, no done pulse.

## Timing
- Reset values: memAddr=0, pc=0, opCode=0, regID1=0, regID2=0, immValue=0, issueValid=0, busy=0, done=0.
- All outputs registered; busy decoded from state register.
- start sampled at edge E0 -> FETCH after E0 -> WAIT after E1 -> issueValid=1 after E2.
- With issueReady held high: issueValid high for 1 cycle per instruction; one instruction every 3 cycles.
- Handshake accepted at edge where issueValid=1 and issueReady=1. After it: issueValid=0 for at least 2 cycles before the next instruction.
- Last instruction accepted at edge Ek -> done=1 after Ek, busy=0 after Ek+1.
- HALT latched at edge Ew (end of WAIT) -> done=1 after Ew.
- Start with limit==0 at E0 -> done=1 after E0.

## Test plan
- Load slots 0..2 = 18'h04000, 18'h0A9FF, 18'h1C812; instrCount=3; issueReady=1; pulse start.
  - Three issues, 3 cycles apart, with opCode/regID1/regID2/immValue = 1/0/0/0x00, 2/5/1/0xFF, 7/1/0/0x12.
  - done pulses 1 cycle after 3rd accept; pc=2.
- Same program with issueReady low for 5 cycles at the 2nd instruction.
  - issueValid and fields stable throughout the stall; no skipped or duplicated issue.
- Slot 1 opCode=4'hF, instrCount=3.
  - Only slot 0 issued; done after slot-1 WAIT; slot 2 never addressed.
- instrCount=0, then instrCount=15 with all slots non-HALT.
  - First: done 1 cycle after start, zero issues.
  - Second: exactly 10 issues, pc ends at 9, memAddr never >9.
- Assert reset while issueValid=1 and issueReady=0.
  - Next cycle: IDLE, all outputs 0, no done.
  - Later start re-runs from slot 0.
- Pulse start again while busy.
  - Ignored: sequence and issue count unchanged.

Source files
------------

// File: rtl/instruction_sequencer_if.sv
// Instruction-memory read port and executor issue handshake of the sequencer.
interface instruction_sequencer_if #(
   parameter int unsigned ADDR_W = 4
);
   logic [ADDR_W-1:0] memAddr;
   logic [17:0]       memData;
   logic [3:0]        opCode;
   logic [2:0]        regID1;
   logic [2:0]        regID2;
   logic [7:0]        immValue;
   logic              issueValid;
   logic              issueReady;

   modport master (
      output memAddr, opCode, regID1, regID2, immValue, issueValid,
      input  memData, issueReady
   );

   modport slave (
      input  memAddr, opCode, regID1, regID2, immValue, issueValid,
      output memData, issueReady
   );
endinterface

// File: rtl/instruction_sequencer.sv
// Walks instruction memory from slot 0, decodes each word and issues it to the
// executor under a valid/ready handshake. Stops on HALT or after the last slot.
module instruction_sequencer #(
   parameter int unsigned DEPTH   = 10,
   parameter int unsigned ADDR_W  = 4,
   parameter logic [3:0]  HALT_OP = 4'hF
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       instrCount,
   instruction_sequencer_if.master bus,
   output logic [ADDR_W-1:0]       pc,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

   state_t            state;
   logic [ADDR_W-1:0] limit;

   // Sequencer FSM: address generation, field latch and issue handshake
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= S_IDLE;
         limit          <= '0;
         pc             <= '0;
         bus.memAddr    <= '0;
         bus.opCode     <= '0;
         bus.regID1     <= '0;
         bus.regID2     <= '0;
         bus.immValue   <= '0;
         bus.issueValid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  limit <= (instrCount > DEPTH_W) ? DEPTH_W : instrCount;
                  if (instrCount == '0) begin
                     state <= S_DONE;
                  end else begin
                     pc          <= '0;
                     bus.memAddr <= '0;
                     state       <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               bus.opCode   <= bus.memData[17:14];
               bus.regID1   <= bus.memData[13:11];
               bus.regID2   <= bus.memData[10:8];
               bus.immValue <= bus.memData[7:0];
               if (bus.memData[17:14] == HALT_OP) begin
                  state <= S_DONE;
               end else begin
                  bus.issueValid <= 1'b1;
                  state          <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (bus.issueValid && bus.issueReady) begin
                  bus.issueValid <= 1'b0;
                  if (pc == limit - 1'b1) begin
                     state <= S_DONE;
                  end else begin
                     pc          <= pc + 1'b1;
                     bus.memAddr <= pc + 1'b1;
                     state       <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Status flags decoded straight from the state register
   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

endmodule
